// File: rtl/shift_sched.sv
// -----------------------------------------------------------------------------
// shift_sched
//
// Two-requester scheduler for a shared 8-bit combinational logical left barrel
// shifter whose single pass shifts by 0..3 bits. The shifter lives outside
// this block; it is driven through sh_di/sh_sel and answers on sh_so within
// the same cycle.
//
// A request is granted round-robin. Its amount is worked off as repeated
// passes of at most 3 bits, and the result is presented with a valid/ready
// handshake.
//
// Optional feature (macro SHIFT_SCHED_SATURATE_EN):
//   When defined, any accepted amount >= 8 clears the operand and jumps
//   straight to DONE. The result is the same as running the passes, which
//   would also give 0x00; only the latency and the shifter activity change.
//
// Parameters:
//   AMT_W      width of the requested shift amount (>= 2)
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req0_valid/di/amt/ready       requester 0 request channel
//   req1_valid/di/amt/ready       requester 1 request channel
//   res_valid/do/id/ready         result channel (id = requester index)
//   busy                          high whenever the FSM is not IDLE
//   sh_di, sh_sel                 drive the external shifter
//   sh_so                         shifter result (combinational return)
//   state_dbg                     current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake semantics (both channels):
//   A transfer happens on the rising edge where valid and ready are both high.
//   A producer that raised valid keeps valid and its payload stable until that
//   edge. On the request side, ready is only ever offered in IDLE, and only to
//   the granted requester. On the result side, res_valid and its payload hold
//   stable in DONE until res_ready is sampled high. ready never depends
//   combinationally on the other channel's ready.
// -----------------------------------------------------------------------------
module shift_sched #(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic [7:0]       req0_di,
    input  logic [AMT_W-1:0] req0_amt,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [7:0]       req1_di,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             req1_ready,

    output logic             res_valid,
    output logic [7:0]       res_do,
    output logic             res_id,
    input  logic             res_ready,

    output logic             busy,

    output logic [7:0]       sh_di,
    output logic [1:0]       sh_sel,
    input  logic [7:0]       sh_so,

    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] MAX_PASS = AMT_W'(3);

    state_t           state;
    state_t           state_nx;
    logic [7:0]       acc;
    logic [AMT_W-1:0] rem;
    logic             id;
    logic             last;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [7:0]       pick_di;
    logic [AMT_W-1:0] pick_amt;
    logic             pick_id;
    logic [AMT_W-1:0] rem_nx;
    logic             sat;

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester always wins. On a tie, the requester that
    // was not granted last time wins. last resets to 1, so requester 0 takes
    // the first tie.
    // -------------------------------------------------------------------------
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last);
        grant1 = req1_valid & (~req0_valid | ~last);
    end

    assign accept     = (state == IDLE) & (grant0 | grant1);
    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;

    // Operand selection for the winning requester.
    always_comb begin
        pick_di  = req0_di;
        pick_amt = req0_amt;
        pick_id  = 1'b0;
        if (grant1) begin
            pick_di  = req1_di;
            pick_amt = req1_amt;
            pick_id  = 1'b1;
        end
    end

`ifdef SHIFT_SCHED_SATURATE_EN
    // Any amount with a bit set at weight 8 or above empties an 8-bit operand.
    assign sat = |(pick_amt >> 3);
`else
    assign sat = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Shifter drive. A pass takes min(rem, 3) bits. Because sel <= rem,
    // rem - sel never wraps. Outside SHIFT the shifter is held at sel = 0.
    // -------------------------------------------------------------------------
    always_comb begin
        sh_di  = acc;
        sh_sel = 2'd0;
        if (state == SHIFT) begin
            sh_sel = (rem > MAX_PASS) ? 2'd3 : rem[1:0];
        end
    end

    assign rem_nx = rem - AMT_W'(sh_sel);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sat || (pick_amt == '0)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (rem_nx == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers. Reset abandons any operation in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 8'h00;
            rem   <= '0;
            id    <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            if (accept) begin
                acc  <= sat ? 8'h00 : pick_di;
                rem  <= sat ? '0 : pick_amt;
                id   <= pick_id;
                last <= pick_id;
            end else if (state == SHIFT) begin
                acc <= sh_so;
                rem <= rem_nx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. acc is only loaded on accept or by a pass, so in DONE it holds
    // the finished result and stays stable under backpressure.
    // -------------------------------------------------------------------------
    assign res_valid = (state == DONE);
    assign res_do    = acc;
    assign res_id    = id;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_shift_sched.sv
module tb_shift_sched;

    localparam int AMT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic [7:0]       req0_di;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_di;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_ready;
    logic             res_valid;
    logic [7:0]       res_do;
    logic             res_id;
    logic             res_ready;
    logic             busy;
    logic [7:0]       sh_di;
    logic [1:0]       sh_sel;
    logic [7:0]       sh_so;
    logic [1:0]       state_dbg;

    shift_sched #(.AMT_W(AMT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_di    (req0_di),
        .req0_amt   (req0_amt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_di    (req1_di),
        .req1_amt   (req1_amt),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_do     (res_do),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy),
        .sh_di      (sh_di),
        .sh_sel     (sh_sel),
        .sh_so      (sh_so),
        .state_dbg  (state_dbg)
    );

    // External shared barrel shifter: logical left shift by 0..3.
    assign sh_so = sh_di << sh_sel;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q[$];   // {id, result}

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] di,
                           input logic [AMT_W-1:0] amt);
        if (r == 0) begin
            req0_valid = v; req0_di = di; req0_amt = amt;
        end else begin
            req1_valid = v; req1_di = di; req1_amt = amt;
        end
    endtask

    // Issue one request on requester r with res_ready high, and collect the result.
    // lat counts edges from the accept edge to the edge that raised res_valid.
    // sels packs the sel of each SHIFT cycle, first pass in bits [1:0].
    task automatic run_op(input int r, input logic [7:0] di, input logic [AMT_W-1:0] amt,
                          output logic [7:0] got_do, output int got_id, output int lat,
                          output int nsh, output logic [15:0] sels, output bit ok);
        bit acc_seen;
        ok = 1'b0; got_do = 8'h00; got_id = 0; lat = 0; nsh = 0; sels = 16'h0;
        acc_seen = 1'b0;
        res_ready = 1'b1;
        set_req(r, 1'b1, di, amt);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((r == 0) ? req0_ready : req1_ready) begin
                acc_seen = 1'b1;
                break;
            end
            step();
        end
        if (!acc_seen) begin
            check("accept_timeout", 0, 1);
            set_req(r, 1'b0, 8'h00, '0);
            return;
        end
        step();                       // accept edge
        set_req(r, 1'b0, 8'h00, '0);
        lat = 1;
        while (!res_valid && lat < 40) begin
            if (state_dbg == 2'd1) begin
                sels = sels | (16'(sh_sel) << (2 * nsh));
                nsh++;
            end
            step();
            lat++;
        end
        if (!res_valid) begin
            check("result_timeout", 0, 1);
            return;
        end
        got_do = res_do;
        got_id = int'(res_id);
        ok = 1'b1;
        step();                       // handoff edge, back to IDLE
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int               r;
        logic [7:0]       di;
        logic [AMT_W-1:0] amt;
        logic [7:0]       exp_do;
        int               exp_lat;
        int               exp_nsh;
        logic [15:0]      exp_sels;
    } vec_t;

    vec_t vecs[10];

`ifdef SHIFT_SCHED_SATURATE_EN
    localparam logic [AMT_W-1:0] RST_AMT = 4'd7;
`else
    localparam logic [AMT_W-1:0] RST_AMT = 4'd9;
`endif

    initial begin
        logic [7:0]  got_do;
        int          got_id, lat, nsh;
        logic [15:0] sels;
        bit          ok;
        logic [8:0]  exp;
        int          grant;
        bit          seen;
        bit          stale;

        vecs[0] = '{0, 8'h81, 4'd5,  8'h20, 3, 2, 16'h000B};
        vecs[1] = '{1, 8'h5A, 4'd0,  8'h5A, 1, 0, 16'h0000};
        vecs[2] = '{0, 8'hFF, 4'd11, 8'h00, 5, 4, 16'h00BF};
        vecs[3] = '{1, 8'h01, 4'd7,  8'h80, 4, 3, 16'h001F};
        vecs[4] = '{0, 8'hC3, 4'd3,  8'h18, 2, 1, 16'h0003};
        vecs[5] = '{1, 8'h0F, 4'd8,  8'h00, 4, 3, 16'h002F};
        vecs[6] = '{0, 8'hAA, 4'd1,  8'h54, 2, 1, 16'h0001};
        vecs[7] = '{1, 8'h96, 4'd2,  8'h58, 2, 1, 16'h0002};
        vecs[8] = '{0, 8'h01, 4'd15, 8'h00, 6, 5, 16'h03FF};
        vecs[9] = '{1, 8'h33, 4'd4,  8'h30, 3, 2, 16'h0007};
`ifdef SHIFT_SCHED_SATURATE_EN
        foreach (vecs[i]) begin
            if (vecs[i].amt >= 4'd8) begin
                vecs[i].exp_lat  = 1;
                vecs[i].exp_nsh  = 0;
                vecs[i].exp_sels = 16'h0;
            end
        end
`endif

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_di = 8'h00; req0_amt = '0;
        req1_valid = 1'b0; req1_di = 8'h00; req1_amt = '0;
        res_ready = 1'b1;

        // ---- reset values ----
        #12;
        check("rst_state",      int'(state_dbg),  0);
        check("rst_busy",       int'(busy),       0);
        check("rst_res_valid",  int'(res_valid),  0);
        check("rst_res_do",     int'(res_do),     0);
        check("rst_res_id",     int'(res_id),     0);
        check("rst_sh_di",      int'(sh_di),      0);
        check("rst_sh_sel",     int'(sh_sel),     0);
        check("rst_req0_ready", int'(req0_ready), 0);
        check("rst_req1_ready", int'(req1_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // ---- tie fairness out of reset: 0,1,0,1 ----
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h82});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h82});
        set_req(0, 1'b1, 8'h11, 4'd1);
        set_req(1, 1'b1, 8'hC1, 4'd1);
        for (int op = 0; op < 4; op++) begin
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    seen = 1'b1;
                    break;
                end
                step();
            end
            if (!seen) begin
                check("tie_accept_timeout", 0, 1);
                break;
            end
            exp = exp_q.pop_front();
            grant = int'(req1_ready);
            check($sformatf("tie%0d_one_ready", op), int'(req0_ready) + int'(req1_ready), 1);
            check($sformatf("tie%0d_grant", op), grant, int'(exp[8]));
            step();
            for (int i = 0; i < 20 && !res_valid; i++) step();
            check($sformatf("tie%0d_valid", op), int'(res_valid), 1);
            check($sformatf("tie%0d_id", op), int'(res_id), int'(exp[8]));
            check($sformatf("tie%0d_do", op), int'(res_do), int'(exp[7:0]));
            step();
        end
        set_req(0, 1'b0, 8'h00, '0);
        set_req(1, 1'b0, 8'h00, '0);
        step();
        check("tie_queue_drained", exp_q.size(), 0);

        // ---- table-driven single requests ----
        foreach (vecs[i]) begin
            run_op(vecs[i].r, vecs[i].di, vecs[i].amt, got_do, got_id, lat, nsh, sels, ok);
            if (ok) begin
                check($sformatf("vec%0d_do", i),   int'(got_do), int'(vecs[i].exp_do));
                check($sformatf("vec%0d_id", i),   got_id,       vecs[i].r);
                check($sformatf("vec%0d_lat", i),  lat,          vecs[i].exp_lat);
                check($sformatf("vec%0d_nsh", i),  nsh,          vecs[i].exp_nsh);
                check($sformatf("vec%0d_sels", i), int'(sels),   int'(vecs[i].exp_sels));
            end
            check($sformatf("vec%0d_idle", i), int'(busy), 0);
        end

        // ---- backpressure ----
        res_ready = 1'b0;
        set_req(0, 1'b1, 8'h03, 4'd2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("bp_accept", int'(seen), 1);
        step();
        set_req(0, 1'b0, 8'h00, '0);
        for (int i = 0; i < 20 && !res_valid; i++) step();
        check("bp_valid", int'(res_valid), 1);
        set_req(1, 1'b1, 8'h10, 4'd0);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp%0d_valid", c), int'(res_valid), 1);
            check($sformatf("bp%0d_do", c), int'(res_do), 8'h0C);
            check($sformatf("bp%0d_id", c), int'(res_id), 0);
            check($sformatf("bp%0d_req0_ready", c), int'(req0_ready), 0);
            check($sformatf("bp%0d_req1_ready", c), int'(req1_ready), 0);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("bp_no_comb_ready", int'(req1_ready), 0);
        step();
        check("bp_idle_after_handoff", int'(state_dbg), 0);
        check("bp_accept_next", int'(req1_ready), 1);
        step();
        set_req(1, 1'b0, 8'h00, '0);
        check("bp_next_valid", int'(res_valid), 1);
        check("bp_next_do", int'(res_do), 8'h10);
        check("bp_next_id", int'(res_id), 1);
        step();

        // ---- reset during the second pass ----
        set_req(0, 1'b1, 8'hFF, RST_AMT);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("rst_mid_accept", int'(seen), 1);
        step();
        set_req(0, 1'b0, 8'h00, '0);
        step();
        check("rst_mid_in_shift", int'(state_dbg), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_state",     int'(state_dbg), 0);
        check("rst_mid_busy",      int'(busy),      0);
        check("rst_mid_res_valid", int'(res_valid), 0);
        check("rst_mid_sh_sel",    int'(sh_sel),    0);
        check("rst_mid_sh_di",     int'(sh_di),     0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (res_valid || busy) stale = 1'b1;
        end
        check("rst_mid_no_stale", int'(stale), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
